// File: rtl/regfile_dump_ctrl_if.sv
// Signal bundle between the register-file dump engine and its surroundings:
// dump request, register-file read ports and the valid/ready trace stream.
interface regfile_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, first_addr, last_addr, rd1, rd2, m_ready,
    output a1, a2, m_valid, m_data, m_addr, m_last, busy, done, err
  );

  modport slave (
    output start, abort, first_addr, last_addr, rd1, rd2, m_ready,
    input  a1, a2, m_valid, m_data, m_addr, m_last, busy, done, err
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks a register range two words per cycle through the a1/a2 read ports and
// streams {value, index} through a small FIFO onto a valid/ready trace output.
module regfile_dump_ctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_dump_ctrl_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  // One extra bit so that stepping past end = 2**ADDR_W - 1 cannot wrap to 0.
  logic [ADDR_W:0]   ptr_q, ptr_d, end_q, end_d;
  logic              done_q, done_d, err_q, err_d;
  logic              flush;

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_p1;
  logic [CntW-1:0]   count_q, free;

  logic              at_end, pair_end, capture, pop, fifo_valid;
  logic [ADDR_W:0]   ptr_p1;
  logic [1:0]        need, push_n;

  assign ptr_p1     = ptr_q + 1'b1;
  assign at_end     = (ptr_q == end_q);
  assign pair_end   = (ptr_p1 == end_q);
  assign need       = at_end ? 2'd1 : 2'd2;
  // Credit comes only from the registered count; same-cycle pops do not help.
  assign free       = CntW'(FIFO_DEPTH) - count_q;
  assign capture    = (state_q == StRead) && !bus.abort && (free >= CntW'(need));
  assign push_n     = capture ? need : 2'd0;
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.m_ready;
  assign wr_ptr_p1  = wr_ptr_q + PtrW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          if (bus.first_addr <= bus.last_addr) begin
            ptr_d   = {1'b0, bus.first_addr};
            end_d   = {1'b0, bus.last_addr};
            state_d = StRead;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (bus.abort) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (capture) begin
          ptr_d = ptr_q + 2'd2;
          if (at_end || pair_end) state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.abort) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (pop && count_q == CntW'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.a1 = '0;
    bus.a2 = '0;
    if (state_q == StRead) begin
      bus.a1 = ptr_q[ADDR_W-1:0];
      bus.a2 = at_end ? ptr_q[ADDR_W-1:0] : ptr_p1[ADDR_W-1:0];
    end
    bus.busy    = (state_q != StIdle);
    bus.done    = done_q;
    bus.err     = err_q;
    bus.m_valid = fifo_valid;
    bus.m_data  = fifo_valid ? mem_data_q[rd_ptr_q] : '0;
    bus.m_addr  = fifo_valid ? mem_addr_q[rd_ptr_q] : '0;
    bus.m_last  = fifo_valid && mem_last_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_data_q <= '{default: '0};
      mem_addr_q <= '{default: '0};
      mem_last_q <= '{default: 1'b0};
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) begin
        mem_data_q[wr_ptr_q] <= bus.rd1;
        mem_addr_q[wr_ptr_q] <= ptr_q[ADDR_W-1:0];
        mem_last_q[wr_ptr_q] <= at_end;
        if (!at_end) begin
          mem_data_q[wr_ptr_p1] <= bus.rd2;
          mem_addr_q[wr_ptr_p1] <= ptr_p1[ADDR_W-1:0];
          mem_last_q[wr_ptr_p1] <= pair_end;
        end
      end
      wr_ptr_q <= wr_ptr_q + PtrW'(push_n);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      count_q  <= count_q + CntW'(push_n) - CntW'(pop);
    end
  end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: directed scenarios plus randomized dumps scored
// against an ordered list of expected beats built from the register contents.
module tb_regfile_dump_ctrl;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] regs [32];

  regfile_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump_ctrl #(.ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // MIPS register file: register 0 always reads zero.
  always_comb begin
    bus.rd1 = (bus.a1 == 5'd0) ? 32'd0 : regs[bus.a1];
    bus.rd2 = (bus.a2 == 5'd0) ? 32'd0 : regs[bus.a2];
  end

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    cyc, beats, done_cnt, done_cyc, err_cnt, err_cyc, last_cnt;
  int    first_beat_cyc, last_beat_cyc, ready_mode;
  bit    busy_seen, valid_seen, busy_at_done, prev_hold;
  logic [31:0] hold_data;
  logic [4:0]  hold_addr;
  logic        hold_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int c);
    case (ready_mode)
      1:       return !(c >= 2 && c <= 11);
      2:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  // Sample the current cycle, score any handshake, then advance one clock.
  task automatic tick();
    beat_t e;
    if (prev_hold) begin
      check("hold_valid", {31'd0, bus.m_valid}, 32'd1);
      check("hold_data", bus.m_data, hold_data);
      check("hold_addr", {27'd0, bus.m_addr}, {27'd0, hold_addr});
      check("hold_last", {31'd0, bus.m_last}, {31'd0, hold_last});
    end
    prev_hold = bus.m_valid && !bus.m_ready && !bus.abort;
    hold_data = bus.m_data;
    hold_addr = bus.m_addr;
    hold_last = bus.m_last;
    if (bus.m_valid && bus.m_ready && !bus.abort) begin
      if (exp_q.size() == 0) begin
        check("beat_extra", {27'd0, bus.m_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat_addr", {27'd0, bus.m_addr}, {27'd0, e.addr});
        check("beat_data", bus.m_data, e.data);
        check("beat_last", {31'd0, bus.m_last}, {31'd0, e.last});
      end
      if (beats == 0) first_beat_cyc = cyc;
      if (bus.m_last) begin
        last_beat_cyc = cyc;
        last_cnt++;
      end
      beats++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = bus.busy;
    end
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.busy) busy_seen = 1'b1;
    if (bus.m_valid) valid_seen = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    bus.m_ready = ready_for(cyc);
  endtask

  task automatic start_dump(input int f, input int l);
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      beat_t b;
      b.addr = i[4:0];
      b.data = (i == 0) ? 32'd0 : regs[i];
      b.last = (i == l);
      exp_q.push_back(b);
    end
    cyc = 0; beats = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    last_cnt = 0; first_beat_cyc = -1; last_beat_cyc = -1;
    busy_seen = 0; valid_seen = 0; busy_at_done = 0;
    bus.first_addr = f[4:0];
    bus.last_addr  = l[4:0];
    bus.m_ready    = ready_for(0);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_regs(input bit random_vals);
    for (int i = 0; i < 32; i++) regs[i] = random_vals ? $urandom() : 32'h100 + i;
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.first_addr = 0; bus.last_addr = 0; bus.m_ready = 0;
    prev_hold = 0; ready_mode = 0;
    fill_regs(1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_a1", {27'd0, bus.a1}, 32'd0);
    check("rst_data", bus.m_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full dump 0..31 at full rate
    start_dump(0, 31);
    check("full_busy_c1", {31'd0, bus.busy}, 32'd1);
    run_until_done(80);
    check("full_beats", beats, 32);
    check("full_left", exp_q.size(), 0);
    check("full_first_cyc", first_beat_cyc, 2);
    check("full_last_cyc", last_beat_cyc, 33);
    check("full_done_cyc", done_cyc, 34);
    check("full_last_cnt", last_cnt, 1);
    check("full_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    tick();
    check("full_done_once", done_cnt, 1);

    // Odd range 5..9
    start_dump(5, 9);
    run_until_done(40);
    check("odd_beats", beats, 5);
    check("odd_left", exp_q.size(), 0);
    check("odd_last_cyc", last_beat_cyc, 6);
    check("odd_done_cyc", done_cyc, last_beat_cyc + 1);

    // Backpressure during cycles 2..11
    ready_mode = 1;
    start_dump(0, 7);
    while (cyc < 11) tick();
    check("bp_a1_frozen", {27'd0, bus.a1}, 32'd4);
    check("bp_valid", {31'd0, bus.m_valid}, 32'd1);
    check("bp_addr0", {27'd0, bus.m_addr}, 32'd0);
    run_until_done(60);
    check("bp_beats", beats, 8);
    check("bp_left", exp_q.size(), 0);
    ready_mode = 0;

    // Invalid range
    start_dump(20, 3);
    repeat (5) tick();
    check("inv_err_cnt", err_cnt, 1);
    check("inv_err_cyc", err_cyc, 1);
    check("inv_done_cyc", done_cyc, 1);
    check("inv_done_cnt", done_cnt, 1);
    check("inv_valid", {31'd0, valid_seen}, 32'd0);
    check("inv_busy", {31'd0, busy_seen}, 32'd0);
    exp_q.delete();

    // Abort at beat 10
    start_dump(0, 31);
    while (beats < 10 && cyc < 60) tick();
    check("ab_addr", {27'd0, bus.m_addr}, 32'd10);
    bus.abort = 1'b1;
    bus.m_ready = 1'b0;
    tick();
    bus.abort = 1'b0;
    check("ab_valid", {31'd0, bus.m_valid}, 32'd0);
    check("ab_done", {31'd0, bus.done}, 32'd1);
    check("ab_busy", {31'd0, bus.busy}, 32'd0);
    check("ab_err", {31'd0, bus.err}, 32'd0);
    repeat (3) tick();
    check("ab_done_once", done_cnt, 1);
    start_dump(2, 3);
    run_until_done(30);
    check("ab_restart_beats", beats, 2);
    check("ab_restart_left", exp_q.size(), 0);

    // Asynchronous reset mid-dump, then clean dump with an ignored start
    start_dump(0, 31);
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_a1", {27'd0, bus.a1}, 32'd0);
    check("arst_data", bus.m_data, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_hold = 0;
    fill_regs(1'b1);
    start_dump(0, 31);
    while (cyc < 5) tick();
    bus.first_addr = 5'd10;
    bus.last_addr  = 5'd12;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    run_until_done(80);
    check("rs_beats", beats, 32);
    check("rs_left", exp_q.size(), 0);
    check("rs_done_cnt", done_cnt, 1);

    // Randomized ranges, data and backpressure
    ready_mode = 2;
    for (int it = 0; it < 20; it++) begin
      int f, l;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      fill_regs(1'b1);
      start_dump(f, l);
      run_until_done(400);
      check("rnd_beats", beats, l - f + 1);
      check("rnd_left", exp_q.size(), 0);
      check("rnd_last_cnt", last_cnt, 1);
      tick();
      check("rnd_idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
